// File: rtl/prog_mod_counter.sv
// Programmable modulus up/down counter with wrap, saturate and one-shot modes.
// Arithmetic is carried one bit wider than the count, so steps near 2**N-1 cannot overflow.
module prog_mod_counter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         syn_clr,
   input  logic         load,
   input  logic [N-1:0] d,
   input  logic         en,
   input  logic         up,
   input  logic [1:0]   mode,
   input  logic [N-1:0] limit,
   input  logic [N-1:0] step,
   output logic [N-1:0] q,
   output logic         max_tick,
   output logic         min_tick,
   output logic         wrap_tick,
   output logic         done
);

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_SAT     = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_WRAP_B  = 2'd3
   } modeE;

   logic [N-1:0] cntQ, cntD;
   logic         tickQ, tickD;
   logic         doneQ, doneD;
   logic [N-1:0] stepEff;
   logic [N:0]   qx, sx, lx, limPlus1, raw, nxt;
   logic         isWrap, isOneShot;

   always_comb begin
      stepEff   = (step < limit) ? step : limit;
      qx        = {1'b0, cntQ};
      sx        = {1'b0, stepEff};
      lx        = {1'b0, limit};
      limPlus1  = lx + {{N{1'b0}}, 1'b1};
      raw       = qx + sx;
      isWrap    = (modeE'(mode) == MODE_WRAP) || (modeE'(mode) == MODE_WRAP_B);
      isOneShot = (modeE'(mode) == MODE_ONESHOT);
      nxt       = qx;
      cntD      = cntQ;
      tickD     = 1'b0;
      // done only survives while the counter stays in one-shot mode
      doneD     = isOneShot ? doneQ : 1'b0;
      if (syn_clr) begin
         cntD  = '0;
         doneD = 1'b0;
      end else if (load) begin
         cntD  = d;
         doneD = 1'b0;
      end else if (en && !doneQ) begin
         tickD = 1'b1;
         if (qx > lx) begin
            nxt = (isWrap && up) ? '0 : lx;
         end else if (up) begin
            if (raw > lx) begin
               nxt = isWrap ? (raw - limPlus1) : lx;
            end else begin
               nxt   = raw;
               tickD = 1'b0;
            end
         end else begin
            if (qx < sx) begin
               nxt = isWrap ? (qx + limPlus1 - sx) : '0;
            end else begin
               nxt   = qx - sx;
               tickD = 1'b0;
            end
         end
         cntD = nxt[N-1:0];
         if (isOneShot && (nxt == (up ? lx : '0))) begin
            doneD = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cntQ  <= '0;
         tickQ <= 1'b0;
         doneQ <= 1'b0;
      end else begin
         cntQ  <= cntD;
         tickQ <= tickD;
         doneQ <= doneD;
      end
   end

   assign q         = cntQ;
   assign wrap_tick = tickQ;
   assign done      = doneQ;
   assign max_tick  = (cntQ == limit);
   assign min_tick  = (cntQ == '0);

endmodule

// File: tb/tb_prog_mod_counter.sv
// Self-checking bench for prog_mod_counter: directed scenarios plus randomized
// traffic compared against an integer reference model of the counting rules.
module tb_prog_mod_counter;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst, syn_clr, load, en, up;
   logic [N-1:0] d, limit, step;
   logic [1:0]   mode;
   logic [N-1:0] q;
   logic         max_tick, min_tick, wrap_tick, done;

   int checks = 0;
   int errors = 0;
   int mQ = 0, mTick = 0, mDone = 0;

   prog_mod_counter #(.N(N)) dut (
      .clk(clk), .rst(rst), .syn_clr(syn_clr), .load(load), .d(d), .en(en),
      .up(up), .mode(mode), .limit(limit), .step(step), .q(q),
      .max_tick(max_tick), .min_tick(min_tick), .wrap_tick(wrap_tick), .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: the counter lives on the integer ring 0..limit
   task automatic model_calc(output int nq, output int nt, output int nd);
      int lim, s, term;
      bit wrapMode, oneShot;
      lim      = int'(limit);
      s        = (int'(step) < lim) ? int'(step) : lim;
      wrapMode = (mode == 2'd0) || (mode == 2'd3);
      oneShot  = (mode == 2'd2);
      nq = mQ;
      nt = 0;
      nd = oneShot ? mDone : 0;
      if (rst) begin
         nq = 0; nd = 0;
      end else if (syn_clr) begin
         nq = 0; nd = 0;
      end else if (load) begin
         nq = int'(d); nd = 0;
      end else if (en && mDone == 0) begin
         if (mQ > lim) begin
            nt = 1;
            nq = (wrapMode && up) ? 0 : lim;
         end else if (up) begin
            nq = mQ + s;
            if (nq > lim) begin
               nt = 1;
               nq = wrapMode ? nq % (lim + 1) : lim;
            end
         end else begin
            nq = mQ - s;
            if (nq < 0) begin
               nt = 1;
               nq = wrapMode ? nq + lim + 1 : 0;
            end
         end
         term = up ? lim : 0;
         if (oneShot && nq == term) nd = 1;
      end
   endtask

   task automatic cyc();
      int nq, nt, nd;
      model_calc(nq, nt, nd);
      @(posedge clk);
      #1;
      mQ = nq; mTick = nt; mDone = nd;
   endtask

   task automatic set_idle();
      rst = 0; syn_clr = 0; load = 0; en = 0; up = 1; d = '0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1; mode = 2'd0; limit = 8'd9; step = 8'd3; en = 1; load = 1; d = 8'd7;
      cyc(); cyc();
      checks++;
      if (q !== 8'd0 || wrap_tick !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state q=%0d tick=%b done=%b expected 0/0/0", q, wrap_tick, done);
      end
      checks++;
      if (min_tick !== 1'b1 || max_tick !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ticks min=%b max=%b expected 1/0", min_tick, max_tick);
      end
      set_idle();
   endtask

   task automatic test_wrap_up();
      int expQ[4]    = '{1, 4, 7, 0};
      int expTick[4] = '{1, 0, 0, 1};
      set_idle();
      mode = 2'd0; limit = 8'd9; step = 8'd3; load = 1; d = 8'd8;
      cyc();
      checks++;
      if (q !== 8'd8) begin
         errors++;
         $display("[TB] FAIL wrap_load q=%0d expected 8", q);
      end
      load = 0; en = 1; up = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (int'(q) != expQ[i] || int'(wrap_tick) != expTick[i]) begin
            errors++;
            $display("[TB] FAIL wrap_seq[%0d] q=%0d tick=%b expected %0d/%0d", i, q, wrap_tick, expQ[i], expTick[i]);
         end
      end
      set_idle();
   endtask

   task automatic test_saturate_down();
      int expQ[4]    = '{70, 20, 0, 0};
      int expTick[4] = '{0, 0, 1, 1};
      set_idle();
      mode = 2'd1; limit = 8'd200; step = 8'd50; load = 1; d = 8'd120;
      cyc();
      load = 0; en = 1; up = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (int'(q) != expQ[i] || int'(wrap_tick) != expTick[i]) begin
            errors++;
            $display("[TB] FAIL sat_seq[%0d] q=%0d tick=%b expected %0d/%0d", i, q, wrap_tick, expQ[i], expTick[i]);
         end
      end
      checks++;
      if (min_tick !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_min_tick got %b expected 1", min_tick);
      end
      set_idle();
   endtask

   task automatic test_oneshot();
      int expQ[4]    = '{100, 200, 255, 255};
      int expDone[4] = '{0, 0, 1, 1};
      set_idle();
      mode = 2'd2; limit = 8'd255; step = 8'd100; syn_clr = 1;
      cyc();
      syn_clr = 0; en = 1; up = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (int'(q) != expQ[i] || int'(done) != expDone[i]) begin
            errors++;
            $display("[TB] FAIL oneshot_seq[%0d] q=%0d done=%b expected %0d/%0d", i, q, done, expQ[i], expDone[i]);
         end
      end
      checks++;
      if (wrap_tick !== 1'b0) begin
         errors++;
         $display("[TB] FAIL oneshot_hold_tick got %b expected 0", wrap_tick);
      end
      en = 0; load = 1; d = 8'd5;
      cyc();
      checks++;
      if (q !== 8'd5 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL oneshot_reload q=%0d done=%b expected 5/0", q, done);
      end
      set_idle();
   endtask

   task automatic test_step_clamp();
      set_idle();
      mode = 2'd0; limit = 8'd10; step = 8'd20; load = 1; d = 8'd3;
      cyc();
      load = 0; en = 1; up = 1;
      cyc();
      checks++;
      if (q !== 8'd2 || wrap_tick !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clamp_up q=%0d tick=%b expected 2/1", q, wrap_tick);
      end
      en = 0; load = 1; d = 8'd3;
      cyc();
      load = 0; en = 1; up = 0;
      cyc();
      checks++;
      if (q !== 8'd4) begin
         errors++;
         $display("[TB] FAIL clamp_down q=%0d expected 4", q);
      end
      set_idle();
   endtask

   task automatic test_out_of_range();
      logic [1:0] modes[2] = '{2'd0, 2'd1};
      int expQ[2] = '{0, 100};
      for (int i = 0; i < 2; i++) begin
         set_idle();
         mode = modes[i]; limit = 8'd100; step = 8'd7; load = 1; d = 8'd250;
         cyc();
         checks++;
         if (q !== 8'd250) begin
            errors++;
            $display("[TB] FAIL oor_load[%0d] q=%0d expected 250", i, q);
         end
         load = 0; en = 1; up = 1;
         cyc();
         checks++;
         if (int'(q) != expQ[i] || wrap_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_step[%0d] q=%0d tick=%b expected %0d/1", i, q, wrap_tick, expQ[i]);
         end
      end
      set_idle();
   endtask

   task automatic test_limit_zero();
      set_idle();
      mode = 2'd0; limit = 8'd0; step = 8'd4; load = 1; d = 8'd5;
      cyc();
      load = 0; en = 1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if (q !== 8'd0 || max_tick !== 1'b1 || min_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL limit_zero[%0d] q=%0d max=%b min=%b expected 0/1/1", i, q, max_tick, min_tick);
         end
      end
      set_idle();
   endtask

   task automatic test_priority_and_abort();
      set_idle();
      mode = 2'd2; limit = 8'd50; step = 8'd9; load = 1; d = 8'd20;
      cyc();
      syn_clr = 1; load = 1; d = 8'd77; en = 1;
      cyc();
      checks++;
      if (q !== 8'd0) begin
         errors++;
         $display("[TB] FAIL prio_clr q=%0d expected 0", q);
      end
      syn_clr = 0; load = 0; up = 1;
      for (int i = 0; i < 7; i++) cyc();
      checks++;
      if (q !== 8'd50 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL run_to_done q=%0d done=%b expected 50/1", q, done);
      end
      rst = 1;
      cyc();
      checks++;
      if (q !== 8'd0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_abort q=%0d done=%b expected 0/0", q, done);
      end
      set_idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         rst     = ($urandom_range(0, 60) == 0);
         syn_clr = ($urandom_range(0, 30) == 0);
         load    = ($urandom_range(0, 12) == 0);
         en      = ($urandom_range(0, 3) != 0);
         up      = $urandom_range(0, 1) != 0;
         d       = N'($urandom);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 20) == 0)
            limit = ($urandom_range(0, 1) != 0) ? N'($urandom_range(0, 12)) : N'($urandom);
         if ($urandom_range(0, 10) == 0) step = N'($urandom_range(0, 255));
         cyc();
         checks++;
         if (int'(q) != mQ || int'(wrap_tick) != mTick || int'(done) != mDone) begin
            errors++;
            $display("[TB] FAIL random[%0d] q=%0d tick=%b done=%b expected %0d/%0d/%0d",
                     i, q, wrap_tick, done, mQ, mTick, mDone);
         end
         checks++;
         if (max_tick !== (mQ == int'(limit)) || min_tick !== (mQ == 0)) begin
            errors++;
            $display("[TB] FAIL random_ticks[%0d] max=%b min=%b expected %0d/%0d",
                     i, max_tick, min_tick, mQ == int'(limit), mQ == 0);
         end
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      mode = 2'd0; limit = '0; step = '0;
      test_reset();
      test_wrap_up();
      test_saturate_down();
      test_oneshot();
      test_step_clamp();
      test_out_of_range();
      test_limit_zero();
      test_priority_and_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
